serial_subtractor: RTL and testbench

SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

---
 rtl/serial_subtractor.sv | 114 +++++++++++
 tb/tb_serial_subtractor.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: a - b - bor_in, LSB first, one bit per clock.
// Optional signed overflow flag enabled by defining SERIAL_SUB_OVF_EN.
module serial_subtractor #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             bor_in,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             bor_out,
   output logic             ovf
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      DONE
   } state_t;

   state_t state;
   state_t state_nx;

   logic [WIDTH-1:0] a_sh;
   logic [WIDTH-1:0] b_sh;
   logic [WIDTH-2:0] res_sh;
   logic [WIDTH-1:0] res_nx;
   logic             bor;
   logic [CW-1:0]    cnt;
   logic             d;
   logic             bor_nx;
   logic             last;

   assign d      = a_sh[0] ^ b_sh[0] ^ bor;
   assign bor_nx = (~a_sh[0] & b_sh[0]) | (~(a_sh[0] ^ b_sh[0]) & bor);
   assign res_nx = {d, res_sh};
   assign last   = (cnt == LAST);

   assign busy = (state == SHIFT);
   assign done = (state == DONE);

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   // Next-state logic: start only matters in IDLE
   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE:    if (start) state_nx = SHIFT;
         SHIFT:   if (last) state_nx = DONE;
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // Operand capture, per-bit shift and result publication
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_sh    <= '0;
         b_sh    <= '0;
         res_sh  <= '0;
         bor     <= 1'b0;
         cnt     <= '0;
         diff    <= '0;
         bor_out <= 1'b0;
      end else if (state == IDLE) begin
         if (start) begin
            a_sh   <= a;
            b_sh   <= b;
            bor    <= bor_in;
            res_sh <= '0;
            cnt    <= '0;
         end
      end else if (state == SHIFT) begin
         a_sh   <= a_sh >> 1;
         b_sh   <= b_sh >> 1;
         bor    <= bor_nx;
         res_sh <= res_nx[WIDTH-1:1];
         if (last) begin
            diff    <= res_nx;
            bor_out <= bor_nx;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end

`ifdef SERIAL_SUB_OVF_EN
   // On the last bit a_sh[0]/b_sh[0] are the operand sign bits and d is the result sign
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ovf <= 1'b0;
      end else if (state == SHIFT && last) begin
         ovf <= (a_sh[0] ^ b_sh[0]) & (a_sh[0] ^ d);
      end
   end
`else
   assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed, table-driven bench for serial_subtractor at WIDTH=8.
// Expected ovf follows SERIAL_SUB_OVF_EN when the bench is built with it.
module tb_serial_subtractor;

   localparam int WIDTH = 8;
`ifdef SERIAL_SUB_OVF_EN
   localparam bit OVF_EN = 1'b1;
`else
   localparam bit OVF_EN = 1'b0;
`endif

   typedef struct {
      logic [7:0] a;
      logic [7:0] b;
      logic       bi;
      logic [7:0] diff;
      logic       bor;
      logic       ovf;
   } vec_t;

   logic             clk;
   logic             rst_n;
   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             bor_in;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] diff;
   logic             bor_out;
   logic             ovf;

   int checks = 0;
   int errors = 0;

   serial_subtractor #(.WIDTH(WIDTH)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .start   (start),
      .a       (a),
      .b       (b),
      .bor_in  (bor_in),
      .busy    (busy),
      .done    (done),
      .diff    (diff),
      .bor_out (bor_out),
      .ovf     (ovf)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string name, input logic [63:0] act,
                        input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic run_op(input vec_t v, input string tag);
      int lat;
      @(posedge clk); #1;
      a = v.a; b = v.b; bor_in = v.bi; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      a = ~v.a; b = ~v.b; bor_in = ~v.bi;
      check({tag, " busy"}, busy, 1);
      lat = 0;
      for (int k = 1; k <= WIDTH + 4; k++) begin
         @(posedge clk); #1;
         if (done) begin
            lat = k;
            break;
         end
      end
      check({tag, " latency"}, lat, WIDTH);
      check({tag, " diff"}, diff, v.diff);
      check({tag, " bor_out"}, bor_out, v.bor);
      check({tag, " ovf"}, ovf, OVF_EN & v.ovf);
      check({tag, " busy_done"}, busy, 0);
      @(posedge clk); #1;
      check({tag, " done_1cyc"}, done, 0);
      check({tag, " diff_hold"}, diff, v.diff);
   endtask

   vec_t vt[8];
   vec_t v;
   int   ndone;
   int   lat;

   initial begin
      vt[0] = '{8'h5A, 8'h3C, 1'b0, 8'h1E, 1'b0, 1'b0};
      vt[1] = '{8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0};
      vt[2] = '{8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1};
      vt[3] = '{8'h10, 8'h10, 1'b1, 8'hFF, 1'b1, 1'b0};
      vt[4] = '{8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1};
      vt[5] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};
      vt[6] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0};
      vt[7] = '{8'h80, 8'h7F, 1'b0, 8'h01, 1'b0, 1'b1};

      rst_n = 1'b1; start = 1'b0;
      a = '0; b = '0; bor_in = 1'b0;
      #1 rst_n = 1'b0;
      #1;
      check("rst busy", busy, 0);
      check("rst done", done, 0);
      check("rst diff", diff, 0);
      check("rst bor_out", bor_out, 0);
      check("rst ovf", ovf, 0);
      #10 rst_n = 1'b1;

      for (int i = 0; i < 8; i++) begin
         run_op(vt[i], $sformatf("vec%0d", i));
      end

      // Restart during SHIFT is ignored; old result holds meanwhile
      @(posedge clk); #1;
      a = 8'h09; b = 8'h04; bor_in = 1'b0; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      ndone = 0; lat = 0;
      for (int k = 1; k <= 16; k++) begin
         if (k == 3) begin
            a = 8'hFF; b = 8'h00; start = 1'b1;
         end
         if (k == 4) start = 1'b0;
         if (k == 5) check("restart diff_hold", diff, vt[7].diff);
         @(posedge clk); #1;
         if (done) begin
            ndone++;
            if (lat == 0) lat = k;
         end
      end
      check("restart ndone", ndone, 1);
      check("restart latency", lat, WIDTH);
      check("restart diff", diff, 8'h05);
      check("restart bor_out", bor_out, 0);

      // Reset in the middle of SHIFT aborts without done
      @(posedge clk); #1;
      a = 8'h55; b = 8'h11; bor_in = 1'b0; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (4) @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      check("abort busy", busy, 0);
      check("abort done", done, 0);
      check("abort diff", diff, 0);
      check("abort bor_out", bor_out, 0);
      check("abort ovf", ovf, 0);
      @(posedge clk); #3 rst_n = 1'b1;
      ndone = 0;
      for (int k = 0; k < 12; k++) begin
         @(posedge clk); #1;
         if (done) ndone++;
      end
      check("abort no_done", ndone, 0);
      v = '{8'h03, 8'h01, 1'b0, 8'h02, 1'b0, 1'b0};
      run_op(v, "post_rst");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
